// File: rtl/acm_table_loader_pkg.sv
// Shared types and widths for the ACM table loader: walk states, ACM bus widths
// and the phase-timer width.
package acm_table_loader_pkg;

  localparam int ACM_AW = 8;
  localparam int ACM_DW = 8;
  localparam int PT_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_VERIFY,
    ST_NEXT,
    ST_DONE
  } acm_state_t;

endpackage

// File: rtl/acm_table_loader_phase_timer.sv
// Loadable down-counter timing the SETUP, STROBE and HOLD phases of one ACM write.
// Loading N-1 on phase entry makes zero rise in the phase's last cycle.
module acm_phase_timer
  import acm_table_loader_pkg::*;
(
  input  logic            pclk,
  input  logic            reset,
  input  logic            load,
  input  logic [PT_W-1:0] load_val,
  output logic            zero
);

  logic [PT_W-1:0] cnt;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/acm_table_loader.sv
// Walks the ACM lookup table from address 0 to LAST_ADDR and copies every valid
// entry into the analog configuration memory with a timed strobe and optional read-back.
module acm_table_loader
  import acm_table_loader_pkg::*;
#(
  parameter int LAST_ADDR     = 255,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int VERIFY        = 1,
  parameter int AUTOSTART     = 1
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              start,
  output logic [ACM_AW-1:0] acmaddr,
  input  logic [ACM_DW-1:0] acmdata,
  input  logic              acmdo,
  output logic [ACM_AW-1:0] acm_addr,
  output logic [ACM_DW-1:0] acm_wdata,
  output logic              acm_wen,
  output logic              acm_ren,
  input  logic [ACM_DW-1:0] acm_rdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ACM_AW-1:0] erraddr,
  output acm_state_t        dbg_state
);

  localparam logic [PT_W-1:0]   SETUP_LD  = PT_W'(SETUP_CYCLES - 1);
  localparam logic [PT_W-1:0]   STROBE_LD = PT_W'(STROBE_CYCLES - 1);
  localparam logic [ACM_AW-1:0] LAST      = ACM_AW'(LAST_ADDR);
  localparam logic              AUTO      = (AUTOSTART != 0);

  acm_state_t        state;
  logic [ACM_AW-1:0] cnt;
  logic              auto_pend;
  logic              vwait;
  logic              t_load;
  logic [PT_W-1:0]   t_val;
  logic              t_zero;

  acm_phase_timer u_timer (
    .pclk     (pclk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .zero     (t_zero)
  );

  // The timer is reloaded on the same edge the FSM enters the phase it times.
  always_comb begin
    t_load = 1'b0;
    t_val  = '0;
    case (state)
      ST_FETCH:  if (acmdo)  begin t_load = 1'b1; t_val = SETUP_LD;  end
      ST_SETUP:  if (t_zero) begin t_load = 1'b1; t_val = STROBE_LD; end
      ST_STROBE: if (t_zero) begin t_load = 1'b1; t_val = SETUP_LD;  end
      default: ;
    endcase
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      auto_pend <= AUTO;
      vwait     <= 1'b0;
      acmaddr   <= '0;
      acm_addr  <= '0;
      acm_wdata <= '0;
      acm_wen   <= 1'b0;
      acm_ren   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      erraddr   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start || auto_pend) begin
            auto_pend <= 1'b0;
            cnt       <= '0;
            acmaddr   <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            erraddr   <= '0;
            state     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (acmdo) begin
            acm_addr  <= cnt;
            acm_wdata <= acmdata;
            state     <= ST_SETUP;
          end else begin
            state <= ST_NEXT;
          end
        end
        ST_SETUP: begin
          if (t_zero) begin
            acm_wen <= 1'b1;
            state   <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (t_zero) begin
            acm_wen <= 1'b0;
            state   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (t_zero) begin
            if (VERIFY != 0) begin
              acm_ren <= 1'b1;
              vwait   <= 1'b0;
              state   <= ST_VERIFY;
            end else begin
              state <= ST_NEXT;
            end
          end
        end
        ST_VERIFY: begin
          // Read data returns in the cycle after the request; acm_wdata still holds the written value.
          if (!vwait) begin
            acm_ren <= 1'b0;
            vwait   <= 1'b1;
          end else begin
            vwait <= 1'b0;
            if (acm_rdata != acm_wdata) begin
              error <= 1'b1;
              if (!error) erraddr <= cnt;
            end
            state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (cnt == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt     <= cnt + 1'b1;
            acmaddr <= cnt + 1'b1;
            state   <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_acm_table_loader.sv
// Bench for acm_table_loader: two configurations share one clock and reset and are
// exercised one after the other against a table/ACM model and an expected-write queue.
module tb_acm_table_loader;
  import acm_table_loader_pkg::*;

  localparam int NI = 2;
  localparam int L0 = 101, S0 = 1, W0 = 2, V0 = 1, A0 = 1;
  localparam int L1 = 3,   S1 = 3, W1 = 1, V1 = 0, A1 = 0;

  logic pclk;
  logic reset;
  logic start [NI];

  logic [7:0] acmaddr   [NI];
  logic [7:0] acmdata   [NI];
  logic       acmdo     [NI];
  logic [7:0] acm_addr  [NI];
  logic [7:0] acm_wdata [NI];
  logic       acm_wen   [NI];
  logic       acm_ren   [NI];
  logic [7:0] acm_rdata [NI];
  logic       busy      [NI];
  logic       done      [NI];
  logic       error     [NI];
  logic [7:0] erraddr   [NI];
  acm_state_t dbg_state [NI];

  logic [7:0] tbl_d   [NI][256];
  logic       tbl_v   [NI][256];
  logic       corrupt [NI][256];

  logic [16:0] exp_q[$];
  int n_total = 0;
  int n_bad   = 0;

  function automatic int cfg_last(int k); return k == 0 ? L0 : L1; endfunction
  function automatic int cfg_s(int k);    return k == 0 ? S0 : S1; endfunction
  function automatic int cfg_w(int k);    return k == 0 ? W0 : W1; endfunction
  function automatic int cfg_v(int k);    return k == 0 ? V0 : V1; endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam logic ID = 1'(g);
    logic [7:0]  mem [256];
    logic [7:0]  rd_q;
    logic [15:0] last_ad;
    logic [15:0] pulse_ad;
    logic [16:0] e;
    logic        prev_wen;
    int          same_cnt;
    int          width;
    int          hold_left;

    acm_table_loader #(
      .LAST_ADDR     (g == 0 ? L0 : L1),
      .SETUP_CYCLES  (g == 0 ? S0 : S1),
      .STROBE_CYCLES (g == 0 ? W0 : W1),
      .VERIFY        (g == 0 ? V0 : V1),
      .AUTOSTART     (g == 0 ? A0 : A1)
    ) u_dut (
      .pclk      (pclk),
      .reset     (reset),
      .start     (start[g]),
      .acmaddr   (acmaddr[g]),
      .acmdata   (acmdata[g]),
      .acmdo     (acmdo[g]),
      .acm_addr  (acm_addr[g]),
      .acm_wdata (acm_wdata[g]),
      .acm_wen   (acm_wen[g]),
      .acm_ren   (acm_ren[g]),
      .acm_rdata (acm_rdata[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .error     (error[g]),
      .erraddr   (erraddr[g]),
      .dbg_state (dbg_state[g])
    );

    // Combinational lookup table and a registered ACM with a corruptible read path.
    assign acmdata[g]   = tbl_d[g][acmaddr[g]];
    assign acmdo[g]     = tbl_v[g][acmaddr[g]];
    assign acm_rdata[g] = rd_q;

    always @(posedge pclk) begin
      if (acm_wen[g]) mem[acm_addr[g]] <= acm_wdata[g];
      if (acm_ren[g]) rd_q <= corrupt[g][acm_addr[g]] ? 8'h00 : mem[acm_addr[g]];
    end

    always @(negedge pclk) begin
      if (reset) begin
        prev_wen  = 1'b0;
        same_cnt  = 0;
        width     = 0;
        hold_left = 0;
        last_ad   = 16'h0;
      end else begin
        if ({acm_addr[g], acm_wdata[g]} == last_ad) same_cnt++;
        else same_cnt = 1;
        last_ad = {acm_addr[g], acm_wdata[g]};
        if (cfg_v(g) == 0 && acm_ren[g]) check("ren_off", 1, 0);
        if (hold_left > 0) begin
          check("hold_ad", last_ad, pulse_ad);
          check("hold_wen", acm_wen[g], 0);
          hold_left--;
        end
        if (acm_wen[g] && !prev_wen) begin
          pulse_ad = last_ad;
          width    = 1;
          check("setup_len", same_cnt - 1, cfg_s(g));
          if (exp_q.size() == 0) begin
            check("wr_unexp", {ID, last_ad}, 0);
          end else begin
            e = exp_q.pop_front();
            check("wr_tag", ID, e[16]);
            check("wr_addr", acm_addr[g], e[15:8]);
            check("wr_data", acm_wdata[g], e[7:0]);
          end
        end else if (acm_wen[g] && prev_wen) begin
          width++;
          check("wen_ad", last_ad, pulse_ad);
        end else if (!acm_wen[g] && prev_wen) begin
          check("wen_width", width, cfg_w(g));
          check("hold_ad", last_ad, pulse_ad);
          hold_left = cfg_s(g) - 1;
        end
        prev_wen = acm_wen[g];
      end
    end
  end

  function automatic int walk_cycles(int k);
    int n = 1;
    for (int a = 0; a <= cfg_last(k); a++)
      n += tbl_v[k][a] ? (2 + 2 * cfg_s(k) + cfg_w(k) + (cfg_v(k) != 0 ? 2 : 0)) : 2;
    return n;
  endfunction

  function automatic logic [8:0] exp_err(int k);
    for (int a = 0; a <= cfg_last(k); a++)
      if (cfg_v(k) != 0 && tbl_v[k][a] && corrupt[k][a] && tbl_d[k][a] != 8'h00)
        return {1'b1, 8'(a)};
    return 9'h0;
  endfunction

  task automatic build_exp(input int k);
    exp_q.delete();
    for (int a = 0; a <= cfg_last(k); a++)
      if (tbl_v[k][a]) exp_q.push_back({1'(k), 8'(a), tbl_d[k][a]});
  endtask

  task automatic chk_idle(input int k);
    check("rst_acmaddr", acmaddr[k], 0);
    check("rst_acm_addr", acm_addr[k], 0);
    check("rst_wdata", acm_wdata[k], 0);
    check("rst_wen", acm_wen[k], 0);
    check("rst_ren", acm_ren[k], 0);
    check("rst_busy", busy[k], 0);
    check("rst_done", done[k], 0);
    check("rst_error", error[k], 0);
    check("rst_erraddr", erraddr[k], 0);
    check("rst_state", dbg_state[k], ST_IDLE);
  endtask

  // Counts cycles from the launching edge to DONE; poke_at pulses START on that cycle.
  task automatic wait_done(input int k, input int exp_n, input int poke_at);
    int   cyc = 0;
    logic got = 1'b0;
    logic last_busy = 1'b0;
    while (cyc < exp_n + 40) begin
      @(negedge pclk);
      cyc++;
      start[k] = (cyc == poke_at);
      if (cyc == 1) begin
        check("go_busy", busy[k], 1);
        check("go_done", done[k], 0);
        check("go_error", error[k], 0);
        check("go_erraddr", erraddr[k], 0);
      end
      if (done[k]) begin
        got = 1'b1;
        break;
      end
      last_busy = busy[k];
    end
    start[k] = 1'b0;
    check("done_seen", got, 1);
    check("done_cycle", cyc, exp_n);
    check("busy_fall", {last_busy, busy[k]}, 2'b10);
    check("exp_left", exp_q.size(), 0);
  endtask

  task automatic rand_table(input int k);
    for (int a = 0; a < 256; a++) begin
      tbl_d[k][a]   = 8'($urandom_range(0, 255));
      tbl_v[k][a]   = ($urandom_range(0, 3) != 0);
      corrupt[k][a] = ($urandom_range(0, 19) == 0);
    end
    tbl_d[k][0] = tbl_d[k][0] | 8'h01;
    tbl_v[k][0] = 1'b1;
  endtask

  logic [8:0] ee;
  int         n;
  int         cyc;

  initial begin
    reset = 1'b1;
    for (int k = 0; k < NI; k++) start[k] = 1'b0;

    rand_table(0);
    for (int a = 0; a < 256; a++) corrupt[0][a] = 1'b0;
    foreach (tbl_v[0][a]) if (a <= 2 || a == 5 || a == 7 || a == 99 || a == 101) tbl_v[0][a] = 1'b1;
    tbl_v[0][100] = 1'b0;
    tbl_d[0][5]   = tbl_d[0][5] | 8'h10;
    tbl_d[0][7]   = tbl_d[0][7] | 8'h10;
    corrupt[0][5] = 1'b1;
    corrupt[0][7] = 1'b1;
    for (int a = 0; a < 256; a++) begin
      tbl_d[1][a]   = ~8'(a);
      tbl_v[1][a]   = 1'b1;
      corrupt[1][a] = 1'b0;
    end
    build_exp(0);

    repeat (3) @(negedge pclk);
    for (int k = 0; k < NI; k++) chk_idle(k);

    // Autostart walk, aborted by reset in the middle of the strobe at address 2.
    reset = 1'b0;
    cyc = 0;
    while (cyc < 200 && !(acm_wen[0] && acm_addr[0] == 8'd2)) begin
      @(negedge pclk);
      cyc++;
    end
    check("abort_reach", cyc < 200, 1);
    @(posedge pclk);
    #1 check("pre_rst_wen", acm_wen[0], 1);
    #1 reset = 1'b1;
    #1 chk_idle(0);
    repeat (3) @(negedge pclk);
    build_exp(0);
    n = walk_cycles(0);
    reset = 1'b0;
    wait_done(0, n, $urandom_range(5, n - 5));
    ee = exp_err(0);
    check("err_flag", error[0], ee[8]);
    check("err_addr", erraddr[0], ee[7:0]);
    repeat (3) @(negedge pclk);
    check("done_hold", done[0], 1);
    check("idle_busy", busy[0], 0);

    // Rewalk by START with a fresh random table and random corruptions.
    rand_table(0);
    build_exp(0);
    n = walk_cycles(0);
    start[0] = 1'b1;
    wait_done(0, n, -1);
    ee = exp_err(0);
    check("err2_flag", error[0], ee[8]);
    check("err2_addr", erraddr[0], ee[7:0]);

    // Long setup/hold, 1-cycle strobe; START lands on the cycle DONE is entered.
    check("u1_idle", dbg_state[1], ST_IDLE);
    build_exp(1);
    n = walk_cycles(1);
    start[1] = 1'b1;
    wait_done(1, n, n - 1);
    repeat (3) @(negedge pclk);
    check("u1_done_hold", done[1], 1);
    check("u1_busy", busy[1], 0);
    check("u1_state", dbg_state[1], ST_DONE);
    check("u1_error", error[1], 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
